branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, PC width in bits.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, predictor entries; power of 2, >=2; IDX_W = log2(BHT_DEPTH).
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port pred_valid, input, 1, fetch-stage lookup request.
REQ-007 SHALL have port pred_pc, input, PC_W, lookup PC.
REQ-008 SHALL have port pred_taken, output, 1, registered prediction.
REQ-009 SHALL have port res_valid, input, 1, execute-stage resolve request.
REQ-010 SHALL have port res_opcode, input, 5, instruction opcode.
REQ-011 SHALL have port res_flags, input, 2, ALU flags; [1]=Z (zero), [0]=N (negative).
REQ-012 SHALL have port res_pc, input, PC_W, PC of the resolving instruction.
REQ-013 SHALL have port res_pred, input, 1, the prediction fetch used for this instruction.
REQ-014 SHALL have port pc_branch_sel_out, output, 1, registered actual-taken.
REQ-015 SHALL have port mispredict, output, 1, registered one-cycle flush pulse.
REQ-016 SHALL have port busy, output, 1, high while the table initialises.
REQ-017 SHALL have ports branch_cnt and mispred_cnt, output, CNT_W each, statistics counters.

Function
REQ-018 SHALL decode BEQ=5'b10011 (taken iff Z=1), BLT=5'b10100 (taken iff N=1), BGT=5'b10101 (taken iff N=0) and BNE=5'b10110 (taken iff Z=0).
REQ-019 SHALL treat any other res_opcode as a non-branch: pc_branch_sel_out=0, mispredict=0, no table update, no count.
REQ-020 SHALL hold BHT_DEPTH 2-bit saturating counters (00 SN, 01 WN, 10 WT, 11 ST), indexed by pc[IDX_W-1:0].
REQ-021 SHALL implement FSM states INIT and RUN; rst forces INIT with sweep index 0.
REQ-022 SHALL, in INIT, write 01 to one entry per cycle, index 0 to BHT_DEPTH-1, then enter RUN; busy=1 for exactly BHT_DEPTH cycles.
REQ-023 SHALL, in INIT, ignore pred_valid and res_valid; pred_taken, pc_branch_sel_out and mispredict stay 0.
REQ-024 SHALL, in RUN, register pred_taken = counter[pred_pc][1] one cycle after pred_valid=1; pred_taken=0 in the cycle after pred_valid=0.
REQ-025 SHALL, in RUN with res_valid and a branch opcode, register pc_branch_sel_out = actual-taken and mispredict = (actual != res_pred) one cycle later.
REQ-026 SHALL, in the same case, increment the entry toward taken or not-taken, saturating at 11/00.
REQ-027 SHALL, in the same case, increment branch_cnt, and also mispred_cnt on mispredict; both saturate at all-ones.
REQ-028 SHALL, when pred_pc and res_pc index the same entry in the same cycle, return the updated counter value (write bypass).
REQ-029 SHALL hold pc_branch_sel_out and mispredict at 0 in any cycle after which no valid branch was resolved.

Reset
REQ-030 SHALL, on rst, drive pred_taken, pc_branch_sel_out, mispredict, branch_cnt and mispred_cnt to 0 and busy to 1 from the next edge.
REQ-031 SHALL, on rst asserted mid-INIT or mid-RUN, restart the sweep from index 0 and discard any in-flight resolve.

Verification
REQ-032 SHALL cover init: rst 1 for 2 cycles, then 0 -> busy=1 for 16 cycles then 0; a lookup of every index returns pred_taken=0.
REQ-033 SHALL cover decode: for each of BEQ/BNE/BLT/BGT with flags 00/01/10/11 and res_pred=0 -> pc_branch_sel_out per REQ-018; mispredict equals pc_branch_sel_out.
REQ-034 SHALL cover training: 2 taken BEQ at res_pc=0x0005 -> next lookup of 0x0005 gives pred_taken=1; 3 further taken -> entry stays 11; 2 not-taken -> entry 01, pred_taken=0.
REQ-035 SHALL cover aliasing and bypass: res_pc=0x0013 and pred_pc=0x0003 (same index) in one cycle with entry 01 and taken -> pred_taken=1 next cycle.
REQ-036 SHALL cover non-branch and stats: opcode 5'b00001 with res_valid -> outputs 0 and counters unchanged; with CNT_W=4, 20 mispredicted branches -> branch_cnt=mispred_cnt=4'hF.
REQ-037 SHALL cover mid-operation reset: rst pulsed during a resolve -> mispredict stays 0, counters 0, busy 1, sweep restarts.

Source files
------------

// File: rtl/branch_unit.sv
// Branch unit: 2-bit saturating-counter branch history table with a power-up
// clearing sweep, branch resolution, one-cycle mispredict pulse and statistics.
module branch_unit #(
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [4:0]       res_opcode,
    input  logic [1:0]       res_flags,
    input  logic [PC_W-1:0]  res_pc,
    input  logic             res_pred,
    output logic             pc_branch_sel_out,
    output logic             mispredict,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_DEPTH - 1);

    localparam logic [4:0] OP_BEQ = 5'b10011;
    localparam logic [4:0] OP_BLT = 5'b10100;
    localparam logic [4:0] OP_BGT = 5'b10101;
    localparam logic [4:0] OP_BNE = 5'b10110;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_sweep_idx;
    logic [1:0]       r_bht [BHT_DEPTH];

    logic             r_pred_taken;
    logic             r_branch_sel;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_run;
    logic             w_is_branch;
    logic             w_actual;
    logic             w_do_update;
    logic             w_bypass;
    logic [1:0]       w_cur_cnt;
    logic [1:0]       w_new_cnt;
    logic [1:0]       w_pred_cnt;
    logic             w_unused_pc;

    assign w_pred_idx  = pred_pc[IDX_W-1:0];
    assign w_res_idx   = res_pc[IDX_W-1:0];
    assign w_unused_pc = ^{pred_pc[PC_W-1:IDX_W], res_pc[PC_W-1:IDX_W]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            ST_INIT: begin
                busy = 1'b1;
                if (r_sweep_idx == LAST_IDX) w_state_next = ST_RUN;
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_run = (r_state == ST_RUN);

    always_comb begin
        w_is_branch = 1'b0;
        w_actual    = 1'b0;
        case (res_opcode)
            OP_BEQ: begin w_is_branch = 1'b1; w_actual =  res_flags[1]; end
            OP_BLT: begin w_is_branch = 1'b1; w_actual =  res_flags[0]; end
            OP_BGT: begin w_is_branch = 1'b1; w_actual = ~res_flags[0]; end
            OP_BNE: begin w_is_branch = 1'b1; w_actual = ~res_flags[1]; end
            default: ;
        endcase
    end

    assign w_do_update = w_run && res_valid && w_is_branch;
    assign w_cur_cnt   = r_bht[w_res_idx];

    always_comb begin
        w_new_cnt = w_cur_cnt;
        if (w_actual) begin
            if (w_cur_cnt != 2'b11) w_new_cnt = w_cur_cnt + 2'b01;
        end else begin
            if (w_cur_cnt != 2'b00) w_new_cnt = w_cur_cnt - 2'b01;
        end
    end

    // A same-cycle resolve to the looked-up entry forwards its new value.
    assign w_bypass   = w_do_update && (w_res_idx == w_pred_idx);
    assign w_pred_cnt = w_bypass ? w_new_cnt : r_bht[w_pred_idx];

    // NOTE: the table has no reset term; the INIT sweep clears it one entry per
    // cycle, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) r_bht[r_sweep_idx] <= 2'b01;
            else if (w_do_update)   r_bht[w_res_idx]   <= w_new_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                     r_sweep_idx <= '0;
        else if (r_state == ST_INIT) r_sweep_idx <= r_sweep_idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_taken  <= 1'b0;
            r_branch_sel  <= 1'b0;
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_pred_taken <= w_run && pred_valid && w_pred_cnt[1];
            r_branch_sel <= w_do_update && w_actual;
            r_mispredict <= w_do_update && (w_actual != res_pred);
            if (w_do_update) begin
                if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                if ((w_actual != res_pred) && (r_mispred_cnt != '1))
                    r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign pred_taken        = r_pred_taken;
    assign pc_branch_sel_out = r_branch_sel;
    assign mispredict        = r_mispredict;
    assign branch_cnt        = r_branch_cnt;
    assign mispred_cnt       = r_mispred_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: init sweep, decode table, predictor training,
// bypass, statistics saturation and mid-operation reset.
module tb_branch_unit;
    localparam int PC_W = 16;
    localparam int BHT_DEPTH = 16;
    localparam int CNT_W = 4;

    localparam logic [4:0] BEQ = 5'b10011;
    localparam logic [4:0] BLT = 5'b10100;
    localparam logic [4:0] BGT = 5'b10101;
    localparam logic [4:0] BNE = 5'b10110;

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [4:0]       res_opcode;
    logic [1:0]       res_flags;
    logic [PC_W-1:0]  res_pc;
    logic             res_pred;
    logic             pc_branch_sel_out;
    logic             mispredict;
    logic             busy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] op;
        logic [1:0] flags;
        logic       pred;
        logic       exp_sel;
        logic       exp_mis;
    } vec_t;

    vec_t vecs [21];

    branch_unit #(.PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .pred_valid        (pred_valid),
        .pred_pc           (pred_pc),
        .pred_taken        (pred_taken),
        .res_valid         (res_valid),
        .res_opcode        (res_opcode),
        .res_flags         (res_flags),
        .res_pc            (res_pc),
        .res_pred          (res_pred),
        .pc_branch_sel_out (pc_branch_sel_out),
        .mispredict        (mispredict),
        .busy              (busy),
        .branch_cnt        (branch_cnt),
        .mispred_cnt       (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until busy drops, bounded so a stuck FSM still ends the run.
    task automatic wait_init(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(name, n, 16);
    endtask

    task automatic resolve(input logic [4:0] op, input logic [1:0] fl,
                           input logic [PC_W-1:0] pc, input logic pr);
        res_valid  = 1'b1;
        res_opcode = op;
        res_flags  = fl;
        res_pc     = pc;
        res_pred   = pr;
        step();
        res_valid  = 1'b0;
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc, input logic exp, input string name);
        pred_valid = 1'b1;
        pred_pc    = pc;
        step();
        pred_valid = 1'b0;
        check(name, pred_taken, exp);
    endtask

    initial begin
        //           op     flags  pred  sel   mis
        vecs[0]  = '{BEQ, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{BEQ, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{BEQ, 2'b10, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{BEQ, 2'b11, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{BNE, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{BNE, 2'b01, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{BNE, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{BNE, 2'b11, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{BLT, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{BLT, 2'b01, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{BLT, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{BLT, 2'b11, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{BGT, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{BGT, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{BGT, 2'b10, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{BGT, 2'b11, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{BEQ, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{BGT, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{5'b00001, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{5'b10111, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{5'b10010, 2'b00, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0;
        res_valid = 1'b0; res_opcode = '0; res_flags = '0; res_pc = '0; res_pred = 1'b0;

        // Reset for two cycles; requests driven during INIT must be ignored.
        step();
        step();
        check("rst_busy", busy, 1);
        check("rst_pred", pred_taken, 0);
        check("rst_sel", pc_branch_sel_out, 0);
        check("rst_mis", mispredict, 0);
        check("rst_bcnt", branch_cnt, 0);
        check("rst_mcnt", mispred_cnt, 0);
        rst = 1'b0;
        pred_valid = 1'b1; pred_pc = 16'h0003;
        res_valid = 1'b1; res_opcode = BEQ; res_flags = 2'b10; res_pc = 16'h0003; res_pred = 1'b0;
        begin
            int n = 0;
            logic seen = 1'b0;
            while (busy === 1'b1 && n < 40) begin
                step();
                seen = seen | pred_taken | pc_branch_sel_out | mispredict;
                n++;
            end
            check("init_busy_cycles", n, 16);
            check("init_outputs_quiet", seen, 0);
        end
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        check("init_bcnt", branch_cnt, 0);

        for (int i = 0; i < BHT_DEPTH; i++)
            lookup(PC_W'(i), 1'b0, $sformatf("init_lookup_%0d", i));

        // Decode table, all resolved at pc 0x0008.
        for (int i = 0; i < 21; i++) begin
            res_valid  = 1'b1;
            res_opcode = vecs[i].op;
            res_flags  = vecs[i].flags;
            res_pc     = 16'h0008;
            res_pred   = vecs[i].pred;
            step();
            check($sformatf("dec%0d_sel", i), pc_branch_sel_out, vecs[i].exp_sel);
            check($sformatf("dec%0d_mis", i), mispredict, vecs[i].exp_mis);
        end
        res_valid = 1'b0;
        step();
        check("idle_sel", pc_branch_sel_out, 0);
        check("idle_mis", mispredict, 0);

        // Training entry 5: 01 -> 10 -> 11.
        resolve(BEQ, 2'b10, 16'h0005, 1'b0);
        check("train_mis", mispredict, 1);
        resolve(BEQ, 2'b10, 16'h0005, 1'b0);
        lookup(16'h0005, 1'b1, "train_after2");
        for (int i = 0; i < 3; i++) resolve(BEQ, 2'b10, 16'h0005, 1'b1);
        lookup(16'h0005, 1'b1, "train_sat11");
        resolve(BEQ, 2'b00, 16'h0005, 1'b1);
        check("train_nt_mis", mispredict, 1);
        lookup(16'h0005, 1'b1, "train_nt1_10");
        resolve(BEQ, 2'b00, 16'h0005, 1'b1);
        lookup(16'h0005, 1'b0, "train_nt2_01");

        // Aliased resolve and lookup in the same cycle on entry 3 (holds 01).
        pred_valid = 1'b1; pred_pc = 16'h0003;
        res_valid = 1'b1; res_opcode = BEQ; res_flags = 2'b10; res_pc = 16'h0013; res_pred = 1'b0;
        step();
        pred_valid = 1'b0; res_valid = 1'b0;
        check("bypass_pred", pred_taken, 1);
        check("bypass_sel", pc_branch_sel_out, 1);
        step();
        check("pred_drop", pred_taken, 0);
        lookup(16'h0003, 1'b1, "alias_entry3");

        // Reset arriving together with a mispredicting resolve and a lookup.
        rst = 1'b1;
        pred_valid = 1'b1; pred_pc = 16'h0005;
        res_valid = 1'b1; res_opcode = BEQ; res_flags = 2'b10; res_pc = 16'h0003; res_pred = 1'b0;
        step();
        pred_valid = 1'b0; res_valid = 1'b0;
        check("midrst_mis", mispredict, 0);
        check("midrst_sel", pc_branch_sel_out, 0);
        check("midrst_pred", pred_taken, 0);
        check("midrst_bcnt", branch_cnt, 0);
        check("midrst_mcnt", mispred_cnt, 0);
        check("midrst_busy", busy, 1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("midinit_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init("midinit_restart");
        lookup(16'h0003, 1'b0, "reinit_entry3");
        lookup(16'h0005, 1'b0, "reinit_entry5");

        // Statistics: non-branch leaves everything alone, then 20 mispredicts.
        resolve(5'b00001, 2'b11, 16'h0002, 1'b1);
        check("nonbr_sel", pc_branch_sel_out, 0);
        check("nonbr_mis", mispredict, 0);
        check("nonbr_bcnt", branch_cnt, 0);
        check("nonbr_mcnt", mispred_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            resolve(BEQ, 2'b00, PC_W'(i), 1'b1);
            if (i == 0) begin
                check("stat_first_bcnt", branch_cnt, 1);
                check("stat_first_mcnt", mispred_cnt, 1);
            end
        end
        check("stat_last_mis", mispredict, 1);
        check("stat_bcnt_sat", branch_cnt, 4'hF);
        check("stat_mcnt_sat", mispred_cnt, 4'hF);
        step();
        check("stat_idle_mis", mispredict, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
